// File: rtl/reg_file.sv
// reg_file: integer register file for the RISC-V decode stage.
//
// 32 x BITS registers, two combinational read ports (rs1/rs2) and one write port (rd)
// that commits on the rising clock edge. Register x0 has no storage and always reads zero.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - write-first forwarding: a read port whose address matches an active,
//               non-x0 write returns data_write in the same cycle. Suppressed during rst.
//   undefined - read ports always return stored contents.
//
// Ports:
//   clk            system clock, all state changes on rising edge
//   rst            synchronous active-high reset; clears x1..x31, wins over a write
//   address_a      read port A index (rs1)
//   address_b      read port B index (rs2)
//   address_write  write port index (rd)
//   write_enable   write strobe, sampled on rising clk
//   data_write     write data, sampled on rising clk
//   data_a         contents of register address_a
//   data_b         contents of register address_b

module reg_file #(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      address_a,
  input  logic [4:0]      address_b,
  input  logic [4:0]      address_write,
  input  logic            write_enable,
  input  logic [BITS-1:0] data_write,
  output logic [BITS-1:0] data_a,
  output logic [BITS-1:0] data_b
);

  localparam int unsigned NumRegs = 32;

  // Entry 0 is deliberately absent: x0 is a constant, not a register.
  logic [BITS-1:0] regs_q [1:NumRegs-1];
  logic [BITS-1:0] regs_d [1:NumRegs-1];

  // A write that will actually commit at the next edge.
  logic write_active;
  assign write_active = write_enable && (address_write != 5'd0) && !rst;

  // Next-state: reset clears everything and drops any concurrent write.
  always_comb begin
    for (int i = 1; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (rst) begin
      for (int i = 1; i < NumRegs; i++) begin
        regs_d[i] = '0;
      end
    end else if (write_active) begin
      regs_d[address_write] = data_write;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NumRegs; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Stored contents seen by each port, x0 forced to zero.
  logic [BITS-1:0] stored_a;
  logic [BITS-1:0] stored_b;

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    if (address_a != 5'd0) begin
      stored_a = regs_q[address_a];
    end
    if (address_b != 5'd0) begin
      stored_b = regs_q[address_b];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding: write_active already excludes x0 and reset, so a port at x0 never
  // matches and keeps reading zero.
  always_comb begin
    data_a = stored_a;
    data_b = stored_b;
    if (write_active && (address_a == address_write)) begin
      data_a = data_write;
    end
    if (write_active && (address_b == address_write)) begin
      data_b = data_write;
    end
  end
`else
  always_comb begin
    data_a = stored_a;
    data_b = stored_b;
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vectors with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.

module tb_reg_file;

  localparam int unsigned BITS = 32;

  logic            clk;
  logic            rst;
  logic [4:0]      address_a;
  logic [4:0]      address_b;
  logic [4:0]      address_write;
  logic            write_enable;
  logic [BITS-1:0] data_write;
  logic [BITS-1:0] data_a;
  logic [BITS-1:0] data_b;

  int n_tests;
  int n_fail;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  reg_file #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .address_a    (address_a),
    .address_b    (address_b),
    .address_write(address_write),
    .write_enable (write_enable),
    .data_write   (data_write),
    .data_a       (data_a),
    .data_b       (data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    write_enable = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      address_a = 5'(i);
      address_b = 5'(31 - i);
      #1;
      n_tests++;
      if (data_a !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_a[%0d]: got %h, want 00000000", i, data_a);
      end
      n_tests++;
      if (data_b !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_b[%0d]: got %h, want 00000000", 31 - i, data_b);
      end
    end
  endtask

  task automatic test_write_read();
    address_write = 5'd1;
    data_write    = 32'haabbccdd;
    write_enable  = 1'b1;
    address_a     = 5'd1;
    address_b     = 5'd2;
    #2;
    n_tests++;
    if (data_a !== (Bypass ? 32'haabbccdd : 32'h0)) begin
      n_fail++;
      $display("FAIL write_pre_edge: got %h, want %h", data_a,
               Bypass ? 32'haabbccdd : 32'h0);
    end
    tick();
    write_enable = 1'b0;
    #2;
    n_tests++;
    if (data_a !== 32'haabbccdd) begin
      n_fail++;
      $display("FAIL write_x1: got %h, want aabbccdd", data_a);
    end
    n_tests++;
    if (data_b !== 32'h0) begin
      n_fail++;
      $display("FAIL untouched_x2: got %h, want 00000000", data_b);
    end
  endtask

  task automatic test_midcycle_change();
    address_b     = 5'd2;
    address_write = 5'd2;
    data_write    = 32'hffffffff;
    write_enable  = 1'b1;
    #2;
    n_tests++;
    if (data_b !== (Bypass ? 32'hffffffff : 32'h0)) begin
      n_fail++;
      $display("FAIL mid_first: got %h, want %h", data_b, Bypass ? 32'hffffffff : 32'h0);
    end
    data_write = 32'ha0a0a0a0;
    #1;
    n_tests++;
    if (data_b !== (Bypass ? 32'ha0a0a0a0 : 32'h0)) begin
      n_fail++;
      $display("FAIL mid_second: got %h, want %h", data_b, Bypass ? 32'ha0a0a0a0 : 32'h0);
    end
    tick();
    write_enable = 1'b0;
    data_write   = 32'h0;
    #2;
    n_tests++;
    if (data_b !== 32'ha0a0a0a0) begin
      n_fail++;
      $display("FAIL mid_commit: got %h, want a0a0a0a0", data_b);
    end
  endtask

  task automatic test_x0_write();
    address_write = 5'd0;
    data_write    = 32'h12345678;
    write_enable  = 1'b1;
    address_a     = 5'd0;
    address_b     = 5'd0;
    #2;
    n_tests++;
    if (data_a !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_pre_edge: got %h, want 00000000", data_a);
    end
    tick();
    write_enable = 1'b0;
    #2;
    n_tests++;
    if (data_b !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_after: got %h, want 00000000", data_b);
    end
    address_a = 5'd1;
    address_b = 5'd2;
    #1;
    n_tests++;
    if (data_a !== 32'haabbccdd || data_b !== 32'ha0a0a0a0) begin
      n_fail++;
      $display("FAIL x0_side_effect: got %h/%h, want aabbccdd/a0a0a0a0", data_a, data_b);
    end
  endtask

  task automatic test_write_disable();
    address_write = 5'd1;
    data_write    = 32'h12345678;
    write_enable  = 1'b0;
    address_a     = 5'd1;
    #2;
    n_tests++;
    if (data_a !== 32'haabbccdd) begin
      n_fail++;
      $display("FAIL we0_pre_edge: got %h, want aabbccdd", data_a);
    end
    tick();
    #2;
    n_tests++;
    if (data_a !== 32'haabbccdd) begin
      n_fail++;
      $display("FAIL we0_after: got %h, want aabbccdd", data_a);
    end
  endtask

  task automatic test_dual_read();
    address_a = 5'd2;
    address_b = 5'd1;
    #1;
    n_tests++;
    if (data_a !== 32'ha0a0a0a0 || data_b !== 32'haabbccdd) begin
      n_fail++;
      $display("FAIL dual_diff: got %h/%h, want a0a0a0a0/aabbccdd", data_a, data_b);
    end
    address_b = 5'd2;
    #1;
    n_tests++;
    if (data_a !== 32'ha0a0a0a0 || data_b !== 32'ha0a0a0a0) begin
      n_fail++;
      $display("FAIL dual_same: got %h/%h, want a0a0a0a0/a0a0a0a0", data_a, data_b);
    end
  endtask

  task automatic test_back_to_back();
    // One write per cycle to x3..x31, then read back on both ports.
    write_enable = 1'b1;
    for (int i = 3; i < 32; i++) begin
      address_write = 5'(i);
      data_write    = 32'h01010101 * i ^ 32'hc0de0000;
      tick();
    end
    write_enable = 1'b0;
    for (int i = 1; i < 32; i++) begin
      logic [31:0] exp;
      if (i == 1) exp = 32'haabbccdd;
      else if (i == 2) exp = 32'ha0a0a0a0;
      else exp = 32'h01010101 * i ^ 32'hc0de0000;
      address_a = 5'(i);
      address_b = 5'(32 - i);
      #1;
      n_tests++;
      if (data_a !== exp) begin
        n_fail++;
        $display("FAIL b2b_a[%0d]: got %h, want %h", i, data_a, exp);
      end
    end
    address_a = 5'd31;
    address_b = 5'd3;
    #1;
    n_tests++;
    if (data_b !== (32'h03030303 ^ 32'hc0de0000)) begin
      n_fail++;
      $display("FAIL b2b_b3: got %h, want %h", data_b, 32'h03030303 ^ 32'hc0de0000);
    end
  endtask

  task automatic test_reset_priority();
    rst           = 1'b1;
    write_enable  = 1'b1;
    address_write = 5'd3;
    data_write    = 32'h55555555;
    address_a     = 5'd3;
    address_b     = 5'd1;
    #2;
    // Bypass is suppressed during reset, so x3 shows its stored value.
    n_tests++;
    if (data_a !== (32'h03030303 ^ 32'hc0de0000)) begin
      n_fail++;
      $display("FAIL rst_no_bypass: got %h, want %h", data_a, 32'h03030303 ^ 32'hc0de0000);
    end
    tick();
    rst = 1'b0;
    write_enable = 1'b0;
    for (int i = 0; i < 32; i++) begin
      address_a = 5'(i);
      address_b = 5'(i);
      #1;
      n_tests++;
      if (data_a !== 32'h0 || data_b !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_clear[%0d]: got %h/%h, want 0/0", i, data_a, data_b);
      end
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    address_a     = 5'd0;
    address_b     = 5'd0;
    address_write = 5'd0;
    write_enable  = 1'b0;
    data_write    = '0;
    test_reset();
    test_write_read();
    test_midcycle_change();
    test_x0_write();
    test_write_disable();
    test_dual_read();
    test_back_to_back();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
